// File: rtl/sdram_test_sequencer.sv
`default_nettype none
// sdram_test_sequencer -- LFSR pattern write / read-back / compare traffic generator for the
// SDRAM controller host port, with error statistics and optional looping. Revision 1.0
module sdram_test_sequencer #(
  parameter int                ADDR_W    = 23,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] ADDR_LAST = 23'h7FFFFF,
  parameter logic [DATA_W-1:0] SEED      = 16'hACE1,
  parameter int                ERR_W     = 16
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              start,
  input  logic              loop,
  output logic              cmd_valid,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [15:0]       pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ_REQ  = 3'd2,
    S_READ_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [ERR_W-1:0]  ERR_MAX = '1;
  localparam logic [DATA_W-1:0] POLY    = DATA_W'(16'hB400);

  state_t            state;
  logic [DATA_W-1:0] lfsr;
  logic [ADDR_W-1:0] addr;

  logic              cmd_accept;
  logic              at_last;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] lfsr_nxt;
  logic [15:0]       pass_inc;
  logic              mismatch;

  function automatic logic [DATA_W-1:0] pass_seed(input logic [15:0] p);
    logic [DATA_W-1:0] s;
    s = SEED ^ DATA_W'(p);
    return (s == '0) ? DATA_W'(1) : s;
  endfunction

  assign cmd_accept = cmd_valid & cmd_ready;
  assign at_last    = (addr == ADDR_LAST);
  assign addr_inc   = addr + ADDR_W'(1);
  assign lfsr_nxt   = {1'b0, lfsr[DATA_W-1:1]} ^ (lfsr[0] ? POLY : '0);
  assign pass_inc   = pass_cnt + 16'd1;
  assign mismatch   = (rd_data != lfsr);

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state          <= S_IDLE;
      lfsr           <= SEED;
      addr           <= '0;
      cmd_valid      <= 1'b0;
      cmd_write      <= 1'b0;
      cmd_addr       <= '0;
      cmd_wdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass_cnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
            pass_cnt       <= '0;
            addr           <= '0;
            lfsr           <= pass_seed(16'd0);
            state          <= S_WRITE;
            busy           <= 1'b1;
            done           <= 1'b0;
            cmd_valid      <= 1'b1;
            cmd_write      <= 1'b1;
            cmd_addr       <= '0;
            cmd_wdata      <= pass_seed(16'd0);
          end
        end
        S_WRITE: begin
          if (cmd_accept) begin
            if (at_last) begin
              // Read phase regenerates the same sequence from the pass seed
              addr      <= '0;
              lfsr      <= pass_seed(pass_cnt);
              state     <= S_READ_REQ;
              cmd_write <= 1'b0;
              cmd_addr  <= '0;
              cmd_wdata <= '0;
            end else begin
              addr      <= addr_inc;
              lfsr      <= lfsr_nxt;
              cmd_addr  <= addr_inc;
              cmd_wdata <= lfsr_nxt;
            end
          end
        end
        S_READ_REQ: begin
          if (cmd_accept) begin
            state     <= S_READ_WAIT;
            cmd_valid <= 1'b0;
          end
        end
        S_READ_WAIT: begin
          if (rd_valid) begin
            if (mismatch) begin
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
              err_flag <= 1'b1;
              if (!err_flag) begin
                first_err_addr <= addr;
                first_err_data <= rd_data;
              end
            end
            if (at_last) begin
              pass_cnt <= pass_inc;
              addr     <= '0;
              if (loop) begin
                lfsr      <= pass_seed(pass_inc);
                state     <= S_WRITE;
                cmd_valid <= 1'b1;
                cmd_write <= 1'b1;
                cmd_addr  <= '0;
                cmd_wdata <= pass_seed(pass_inc);
              end else begin
                lfsr  <= lfsr_nxt;
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              addr      <= addr_inc;
              lfsr      <= lfsr_nxt;
              state     <= S_READ_REQ;
              cmd_valid <= 1'b1;
              cmd_addr  <= addr_inc;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_test_sequencer.sv
`default_nettype none
// tb_sdram_test_sequencer -- controller/memory model with random stalls and a pattern-level
// reference for the expected write stream, read order and error statistics. Revision 1.0
`timescale 1ns/1ps
module tb_sdram_test_sequencer;
  localparam int                ADDR_W    = 23;
  localparam int                DATA_W    = 16;
  localparam int                ERR_W     = 2;
  localparam int                N_WORDS   = 8;
  localparam logic [ADDR_W-1:0] ADDR_LAST = 23'd7;
  localparam logic [15:0]       SEED      = 16'hACE1;
  localparam int                RD_LAT    = 3;
  localparam int                ERR_SAT   = 3;

  logic              clk = 1'b0;
  logic              rst_n, start, loop, cmd_ready, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              cmd_valid, cmd_write, busy, done, err_flag;
  logic [ADDR_W-1:0] cmd_addr, first_err_addr;
  logic [DATA_W-1:0] cmd_wdata, first_err_data;
  logic [ERR_W-1:0]  err_cnt;
  logic [15:0]       pass_cnt;

  always #5 clk = ~clk;

  sdram_test_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_LAST(ADDR_LAST), .SEED(SEED), .ERR_W(ERR_W)
  ) dut (
    .sys_clk(clk), .sys_reset_n(rst_n), .start(start), .loop(loop),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .err_flag(err_flag), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data), .pass_cnt(pass_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word idx of the pattern for a given pass, straight from the seed/polynomial rules
  function automatic logic [15:0] ref_word(input int pass, input int idx);
    logic [15:0] v;
    v = SEED ^ 16'(pass);
    if (v == 16'h0000) v = 16'h0001;
    for (int k = 0; k < idx; k++) v = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    return v;
  endfunction

  logic [15:0] mem [N_WORDS];
  int          corrupt_mode, ready_low_pct, cyc;
  int          m_pass, m_wi, m_ri, m_rets, m_passes_done, m_err, m_first_addr;
  bit          m_err_seen;
  logic [15:0] m_first_data;
  bit          rd_pending, last_ret_seen, last_ret_loop;
  int          rd_cnt, rd_idx, first_wr_cyc, last_wr_cyc;
  bit          prev_stall;
  logic        prev_write;
  logic [ADDR_W-1:0] prev_addr;
  logic [15:0] prev_wdata;

  task automatic model_clear();
    m_pass = 0; m_wi = 0; m_ri = 0; m_rets = 0; m_passes_done = 0;
    m_err = 0; m_err_seen = 0; m_first_addr = 0; m_first_data = 16'h0;
    rd_pending = 0; rd_cnt = 0; last_ret_seen = 0; last_ret_loop = 0; prev_stall = 0;
    first_wr_cyc = -1; last_wr_cyc = -1;
  endtask

  // One cycle of the controller model: observe at the falling edge, drive for the next rising edge
  task automatic step();
    logic [15:0] v;
    @(negedge clk);
    cyc++;
    rd_valid = 1'b0;
    rd_data  = $urandom();
    if (last_ret_seen) begin
      last_ret_seen = 0;
      m_passes_done++;
      if (last_ret_loop) begin
        m_pass++; m_wi = 0; m_ri = 0; m_rets = 0;
      end
    end
    if (prev_stall) begin
      check("stall_valid", cmd_valid, 1'b1);
      check("stall_write", cmd_write, prev_write);
      check("stall_addr", cmd_addr, prev_addr);
      if (prev_write) check("stall_wdata", cmd_wdata, prev_wdata);
    end
    if (rd_pending) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        v = mem[rd_idx];
        if (corrupt_mode == 1 && rd_idx == 5) v = v ^ 16'h0001;
        if (corrupt_mode == 2) v = 16'h0000;
        rd_valid = 1'b1; rd_data = v; rd_pending = 0;
        if (v != ref_word(m_pass, rd_idx)) begin
          if (m_err < ERR_SAT) m_err++;
          if (!m_err_seen) begin
            m_err_seen = 1; m_first_addr = rd_idx; m_first_data = v;
          end
        end
        m_rets++;
        if (rd_idx == N_WORDS - 1) begin
          last_ret_seen = 1; last_ret_loop = loop;
        end
      end
    end
    cmd_ready = ($urandom_range(99) >= ready_low_pct);
    if (cmd_valid && cmd_ready) begin
      if (cmd_write) begin
        check("wr_addr", cmd_addr, m_wi);
        check("wr_data", cmd_wdata, ref_word(m_pass, m_wi));
        if (cmd_addr < N_WORDS) mem[cmd_addr[2:0]] = cmd_wdata;
        if (m_wi == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        m_wi++;
      end else begin
        check("rd_single_outstanding", rd_pending, 1'b0);
        check("rd_after_all_writes", m_wi, N_WORDS);
        check("rd_addr", cmd_addr, m_ri);
        rd_pending = 1; rd_cnt = RD_LAT; rd_idx = m_ri % N_WORDS;
        m_ri++;
      end
    end
    prev_stall = cmd_valid && !cmd_ready;
    prev_write = cmd_write; prev_addr = cmd_addr; prev_wdata = cmd_wdata;
  endtask

  task automatic do_start();
    model_clear();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check({tag, "_no_timeout"}, n < budget, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
    check({tag, "_cmd_write"}, cmd_write, 1'b0);
    check({tag, "_cmd_addr"}, cmd_addr, 0);
    check({tag, "_cmd_wdata"}, cmd_wdata, 0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err_flag"}, err_flag, 1'b0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_first_err_addr"}, first_err_addr, 0);
    check({tag, "_first_err_data"}, first_err_data, 0);
    check({tag, "_pass_cnt"}, pass_cnt, 0);
  endtask

  task automatic check_results(input string tag, input int exp_passes);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
    check({tag, "_pass_cnt"}, pass_cnt, exp_passes);
    check({tag, "_model_passes"}, m_passes_done, exp_passes);
    check({tag, "_writes"}, m_wi, N_WORDS);
    check({tag, "_reads"}, m_rets, N_WORDS);
    check({tag, "_err_cnt"}, err_cnt, m_err);
    check({tag, "_err_flag"}, err_flag, m_err_seen);
    check({tag, "_first_err_addr"}, first_err_addr, m_err_seen ? m_first_addr : 0);
    check({tag, "_first_err_data"}, first_err_data, m_err_seen ? m_first_data : 16'h0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; loop = 1'b0; cmd_ready = 1'b0;
    rd_valid = 1'b0; rd_data = '0; cyc = 0;
    corrupt_mode = 0; ready_low_pct = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check_idle("after_release");

    // Ideal memory, always ready: back-to-back writes, clean pass
    do_start();
    run_until_done("s1", 2000);
    check_results("s1", 1);
    check("s1_err_cnt_zero", err_cnt, 0);
    check("s1_writes_back_to_back", last_wr_cyc - first_wr_cyc, N_WORDS - 1);

    // Bit 0 flipped on readback of word 5
    corrupt_mode = 1;
    do_start();
    run_until_done("s2", 2000);
    check_results("s2", 1);
    check("s2_err_cnt", err_cnt, 1);
    check("s2_first_err_addr", first_err_addr, 5);
    check("s2_first_err_data", first_err_data, ref_word(0, 5) ^ 16'h0001);

    // Random stalls
    corrupt_mode = 0; ready_low_pct = 30;
    do_start();
    run_until_done("s3", 4000);
    check_results("s3", 1);
    check("s3_err_flag", err_flag, 1'b0);

    // Looping for three passes
    loop = 1'b1;
    do_start();
    n = 0;
    while (m_passes_done < 2 && n < 6000) begin
      step();
      n++;
    end
    check("s4_two_passes_no_timeout", n < 6000, 1'b1);
    check("s4_busy_while_looping", busy, 1'b1);
    loop = 1'b0;
    run_until_done("s4", 4000);
    check_results("s4", 3);
    check("s4_pass1_seed", ref_word(1, 0), SEED ^ 16'h0001);

    // All-zero readback, counter saturates
    corrupt_mode = 2; ready_low_pct = 0;
    do_start();
    run_until_done("s5", 2000);
    check_results("s5", 1);
    check("s5_err_cnt_sat", err_cnt, 2'b11);
    check("s5_first_err_addr", first_err_addr, 0);
    check("s5_first_err_data", first_err_data, 0);

    // Reset in the middle of the second write phase
    loop = 1'b1;
    do_start();
    n = 0;
    while (m_passes_done < 1 && n < 2000) begin
      step();
      n++;
    end
    repeat (3) step();
    check("s6_pre_reset_busy", busy, 1'b1);
    check("s6_pre_reset_pass", pass_cnt, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("s6_async_reset");
    model_clear();
    loop = 1'b0; corrupt_mode = 0;
    step();
    rst_n = 1'b1;
    step();
    check_idle("s6_after_release");
    do_start();
    run_until_done("s6", 2000);
    check_results("s6", 1);
    check("s6_clean_err_cnt", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
